// File: rtl/wc_tile_ctrl.sv
// Tile sequencer for a windowed-compute (WC) datapath: assembles 5-sample windows
// from a serial stream, issues them under FIFO credit, and buffers results as output tiles.
module wc_tile_ctrl #(
  parameter int W   = 10,
  parameter int LAT = 2,
  parameter int FD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_tiles,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic [5*W-1:0]   wc_D,
  input  logic [3*W-1:0]   wc_Z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3*W-1:0]   m_data,
  output logic             busy,
  output logic             done
);

  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [5*W-1:0]     win_q, win_d;
  logic [2:0]         new_cnt_q, new_cnt_d;
  logic [7:0]         issued_q, issued_d;
  logic [7:0]         num_q, num_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic [3*W-1:0]     mem_q [FD];
  logic [3*W-1:0]     mem_d [FD];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               active, credit, issue, accept, push, pop;
  logic [2:0]         need;
  logic [31:0]        inflight;
  logic [LAT:0]       vld_ext;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    new_cnt_d = new_cnt_q;
    issued_d  = issued_q;
    num_d     = num_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    done_d    = 1'b0;

    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 32'(vld_q[i]);

    active  = (state_q == FILL) || (state_q == RUN);
    need    = (state_q == FILL) ? 3'd5 : 3'd3;
    s_ready = active && (new_cnt_q < need);
    // Credit counts results still inside the WC pipe so the FIFO can never overflow.
    credit  = (inflight + 32'(cnt_q)) < 32'(FD);
    issue   = active && (new_cnt_q == need) && credit;
    accept  = s_valid && s_ready;
    push    = vld_q[LAT-1];
    pop     = (cnt_q != '0) && m_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d     = num_tiles;
          issued_d  = '0;
          new_cnt_d = '0;
          win_d     = '0;
          state_d   = (num_tiles == 8'd0) ? DRAIN : FILL;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          win_d     = {s_data, win_q[5*W-1:W]};
          new_cnt_d = new_cnt_q + 3'd1;
        end
        if (issue) begin
          new_cnt_d = '0;
          issued_d  = issued_q + 8'd1;
          state_d   = ((issued_q + 8'd1) == num_q) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && (cnt_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_ext = {vld_q, issue};
    vld_d   = vld_ext[LAT-1:0];

    if (push) begin
      mem_d[wr_q] = wc_Z;
      wr_d = (wr_q == PW'(FD - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) rd_d = (rd_q == PW'(FD - 1)) ? '0 : rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    wc_D    = win_q;
    m_valid = (cnt_q != '0);
    m_data  = m_valid ? mem_q[rd_q] : '0;
    busy    = (state_q != IDLE);
    done    = done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      new_cnt_q <= '0;
      issued_q  <= '0;
      num_q     <= '0;
      vld_q     <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      new_cnt_q <= new_cnt_d;
      issued_q  <= issued_d;
      num_q     <= num_d;
      vld_q     <= vld_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_wc_tile_ctrl.sv
// Self-checking bench for wc_tile_ctrl: a WC stub (3 sliding sums, LAT cycles late),
// a queue-based job model compared every cycle, and directed job scenarios.
module tb_wc_tile_ctrl;

  localparam int W   = 10;
  localparam int LAT = 2;
  localparam int FD  = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic            clk, rst, start, s_valid, s_ready, m_valid, m_ready, busy, done;
  logic [7:0]      num_tiles;
  logic [W-1:0]    s_data;
  logic [5*W-1:0]  wc_D;
  logic [3*W-1:0]  wc_Z, m_data;

  wc_tile_ctrl #(.W(W), .LAT(LAT), .FD(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wc_D(wc_D), .wc_Z(wc_Z),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5*W-1:0] packWin(input int w[5]);
    logic [5*W-1:0] r;
    for (int k = 0; k < 5; k++) r[W*k +: W] = W'(w[k]);
    return r;
  endfunction

  function automatic logic [3*W-1:0] fz(input logic [5*W-1:0] d);
    logic [3*W-1:0] r;
    for (int j = 0; j < 3; j++)
      r[W*j +: W] = d[W*j +: W] + d[W*(j+1) +: W] + d[W*(j+2) +: W];
    return r;
  endfunction

  // Job model state
  int              mst;
  int              mwin[5];
  int              mnew, missued, mnum;
  bit              mdone;
  int              inf_due[$];
  logic [3*W-1:0]  inf_val[$];
  logic [3*W-1:0]  mfifo[$];

  // Observations gathered for the directed scenarios
  logic [3*W-1:0]  got[$];
  logic [5*W-1:0]  issued_win[$];
  int              issue_cyc[$];
  int              accepts, busy_cycles, done_count, first_mv;
  bit              sready_seen;
  logic [5*W-1:0]  dh[16];

  task automatic modelReset();
    mst = M_IDLE;
    for (int k = 0; k < 5; k++) mwin[k] = 0;
    mnew = 0; missued = 0; mnum = 0; mdone = 0;
    inf_due.delete(); inf_val.delete(); mfifo.delete();
  endtask

  task automatic clearStats();
    got.delete(); issued_win.delete(); issue_cyc.delete();
    accepts = 0; busy_cycles = 0; done_count = 0; first_mv = -1; sready_seen = 0;
  endtask

  // Compare the DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    int need;
    bit act, e_sready, e_issue, e_mvalid, ndone;
    if (rst) modelReset();
    act      = (mst == M_FILL) || (mst == M_RUN);
    need     = (mst == M_FILL) ? 5 : 3;
    e_sready = act && (mnew < need);
    e_issue  = act && (mnew == need) && ((inf_due.size() + mfifo.size()) < FD);
    e_mvalid = mfifo.size() > 0;

    checkOutput("s_ready", 64'(s_ready), 64'(e_sready));
    checkOutput("busy", 64'(busy), 64'(mst != M_IDLE));
    checkOutput("done", 64'(done), 64'(mdone));
    checkOutput("wc_D", 64'(wc_D), 64'(packWin(mwin)));
    checkOutput("m_valid", 64'(m_valid), 64'(e_mvalid));
    if (e_mvalid) checkOutput("m_data", 64'(m_data), 64'(mfifo[0]));

    if (s_valid && s_ready) accepts++;
    if (m_valid && m_ready) got.push_back(m_data);
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (busy) busy_cycles++;
    if (s_ready) sready_seen = 1;
    if (done) done_count++;

    if (!rst) begin
      ndone = (mst == M_DRAIN) && (inf_due.size() == 0) && (mfifo.size() == 0);
      if (e_mvalid && m_ready) void'(mfifo.pop_front());
      if (inf_due.size() > 0 && inf_due[0] == cyc) begin
        mfifo.push_back(inf_val[0]);
        void'(inf_due.pop_front());
        void'(inf_val.pop_front());
      end
      case (mst)
        M_IDLE: if (start) begin
          mnum = int'(num_tiles); missued = 0; mnew = 0;
          for (int k = 0; k < 5; k++) mwin[k] = 0;
          mst = (mnum == 0) ? M_DRAIN : M_FILL;
        end
        M_FILL, M_RUN: begin
          if (e_issue) begin
            inf_due.push_back(cyc + LAT);
            inf_val.push_back(fz(packWin(mwin)));
            issued_win.push_back(packWin(mwin));
            issue_cyc.push_back(cyc);
            missued++;
            mnew = 0;
            mst = (missued == mnum) ? M_DRAIN : M_RUN;
          end else if (s_valid && e_sready) begin
            for (int k = 0; k < 4; k++) mwin[k] = mwin[k+1];
            mwin[4] = int'(s_data);
            mnew++;
          end
        end
        default: if (ndone) mst = M_IDLE;
      endcase
      mdone = ndone;
    end

    // WC stub: result of the window presented LAT cycles ago
    dh[cyc % 16] = wc_D;
    wc_Z = (cyc >= LAT) ? fz(dh[(cyc - LAT) % 16]) : '0;
  end

  task automatic applyStimulus(input int ntiles);
    @(posedge clk); #1;
    start = 1'b1; num_tiles = 8'(ntiles);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feedSamples(input int first, input int count);
    int fed, t;
    bit ok;
    fed = 0;
    for (int i = 0; i < count; i++) begin
      ok = 0; t = 0;
      s_valid = 1'b1; s_data = W'(first + i);
      while (!ok && t < 400) begin
        @(negedge clk); ok = s_ready;
        @(posedge clk); #1; t++;
      end
      if (!ok) break;
      fed++;
    end
    s_valid = 1'b0;
    checkOutput("feed_complete", 64'(fed), 64'(count));
  endtask

  task automatic waitDone(input int budget);
    int t;
    bit seen;
    t = 0; seen = 0;
    while (!seen && t < budget) begin
      @(negedge clk); seen = done;
      @(posedge clk); #1; t++;
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    logic [5*W-1:0] exp_win;
    logic [3*W-1:0] exp_z;
    int             wv[5];
    rst = 1'b1; start = 1'b0; num_tiles = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    wc_Z = '0;
    modelReset();
    clearStats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_wc_D", 64'(wc_D), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-tile job with an always-ready sink
    m_ready = 1'b1;
    clearStats();
    applyStimulus(2);
    feedSamples(1, 8);
    waitDone(100);
    exp_win = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    checkOutput("job2_issues", 64'(issued_win.size()), 64'd2);
    if (issued_win.size() == 2) begin
      checkOutput("job2_win1", 64'(issued_win[0]), 64'(exp_win));
      exp_win = {10'd8, 10'd7, 10'd6, 10'd5, 10'd4};
      checkOutput("job2_win2", 64'(issued_win[1]), 64'(exp_win));
      checkOutput("job2_latency", 64'(first_mv - issue_cyc[0]), 64'd3);
    end
    checkOutput("job2_tiles", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      exp_z = {10'd12, 10'd9, 10'd6};
      checkOutput("job2_tile1", 64'(got[0]), 64'(exp_z));
      exp_z = {10'd21, 10'd18, 10'd15};
      checkOutput("job2_tile2", 64'(got[1]), 64'(exp_z));
    end
    checkOutput("job2_done_count", 64'(done_count), 64'd1);

    // Eight tiles against a stalled sink: credit stops the job after FD issues
    m_ready = 1'b0;
    clearStats();
    applyStimulus(8);
    fork
      feedSamples(20, 26);
      begin
        repeat (80) @(posedge clk);
        #1;
        checkOutput("stall_accepts", 64'(accepts), 64'd17);
        checkOutput("stall_issues", 64'(issue_cyc.size()), 64'd4);
        checkOutput("stall_s_ready", 64'(s_ready), 64'd0);
        checkOutput("stall_no_pop", 64'(got.size()), 64'd0);
        m_ready = 1'b1;
      end
    join
    waitDone(200);
    checkOutput("stall_tiles", 64'(got.size()), 64'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      for (int j = 0; j < 5; j++) wv[j] = 20 + 3*k + j;
      checkOutput("stall_tile_order", 64'(got[k]), 64'(fz(packWin(wv))));
    end

    // Empty job
    clearStats();
    applyStimulus(0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("empty_busy_cycles", 64'(busy_cycles), 64'd1);
    checkOutput("empty_done", 64'(done_count), 64'd1);
    checkOutput("empty_no_sready", 64'(sready_seen), 64'd0);

    // start pulsed while running must not disturb the job
    clearStats();
    applyStimulus(3);
    fork
      feedSamples(40, 11);
      begin
        repeat (9) @(posedge clk);
        #1;
        checkOutput("ignore_busy", 64'(busy), 64'd1);
        start = 1'b1; num_tiles = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    waitDone(100);
    checkOutput("ignore_tiles", 64'(got.size()), 64'd3);
    checkOutput("ignore_issues", 64'(issue_cyc.size()), 64'd3);
    checkOutput("ignore_done", 64'(done_count), 64'd1);

    // Reset with two tiles in flight, then a fresh single-tile job
    m_ready = 1'b0;
    applyStimulus(2);
    feedSamples(50, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    clearStats();
    @(negedge clk);
    checkOutput("mid_rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("mid_rst_m_data", 64'(m_data), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_wc_D", 64'(wc_D), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post_rst_quiet", 64'(got.size() + done_count), 64'd0);
    applyStimulus(1);
    feedSamples(9, 5);
    waitDone(100);
    checkOutput("post_rst_tiles", 64'(got.size()), 64'd1);
    exp_win = {10'd13, 10'd12, 10'd11, 10'd10, 10'd9};
    if (issued_win.size() > 0) checkOutput("post_rst_win", 64'(issued_win[0]), 64'(exp_win));
    exp_z = {10'd36, 10'd33, 10'd30};
    if (got.size() > 0) checkOutput("post_rst_tile", 64'(got[0]), 64'(exp_z));
    checkOutput("post_rst_done", 64'(done_count), 64'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wc_tile_ctrl.md
WC_TILE_CTRL -- requirements
Module: wc_tile_ctrl

Interface
REQ-001 Parameter W, default 10, sample width in bits.
REQ-002 Parameter LAT, default 2, fixed WC datapath latency in cycles from D capture to valid Z.
REQ-003 Parameter FD, default 4, output FIFO depth in entries.
REQ-004 Port clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port start  in  1  single-cycle job request; honoured only in IDLE.
REQ-007 Port num_tiles  in  8  number of output tiles in the job; latched when start is honoured.
REQ-008 Port s_valid / s_ready  in / out  1 / 1  input sample handshake.
REQ-009 Port s_data  in  W  input sample, serial stream.
REQ-010 Port wc_D  out  5*W  window to WC; slot k at bits [W*k+W-1 : W*k]; slot0 oldest.
REQ-011 Port wc_Z  in  3*W  WC result, valid exactly LAT cycles after issue.
REQ-012 Port m_valid / m_ready  out / in  1 / 1  output tile handshake.
REQ-013 Port m_data  out  3*W  output tile, a copy of the captured wc_Z.
REQ-014 Port busy / done  out / out  1 / 1  busy: not IDLE; done: one-cycle job-completion pulse.

Function
REQ-015 States SHALL be IDLE, FILL, RUN and DRAIN.
REQ-016 IDLE->FILL on start; if num_tiles=0, IDLE->DRAIN instead.
REQ-017 On an accepted sample (s_valid&&s_ready), slots SHALL shift down one position (slot0 discarded) and s_data SHALL enter slot4.
REQ-018 need SHALL be 5 in FILL and 3 in RUN; s_ready=1 only in FILL/RUN while new-samples-since-last-issue < need.
REQ-019 Issue SHALL occur in a cycle where new-samples = need and credit is available; in that cycle, s_ready=0 and wc_D holds the complete window.
REQ-020 Credit SHALL mean in-flight count + FIFO count < FD; in-flight SHALL be the number of issues not yet captured.
REQ-021 On issue, new-samples SHALL clear to 0, tiles_issued SHALL increment, and FILL->RUN.
REQ-022 If tiles_issued reaches num_tiles on an issue, the state SHALL go to DRAIN.
REQ-023 A LAT-deep valid shift register SHALL track issues; wc_Z SHALL be written to the FIFO at the end of cycle issue+LAT.
REQ-024 Earliest m_valid SHALL be cycle issue+LAT+1; m_data SHALL be the FIFO head; it SHALL pop on m_valid&&m_ready.
REQ-025 A simultaneous FIFO push and pop SHALL both take effect; the credit rule SHALL guarantee the FIFO never overflows.
REQ-026 A tile stalled by backpressure SHALL hold input (s_ready=0), never drop data.
REQ-027 DRAIN->IDLE when in-flight=0 and FIFO empty; done SHALL be 1 in the cycle after that transition edge, otherwise 0.
REQ-028 start outside IDLE SHALL be ignored; window contents SHALL not carry between jobs (new-samples cleared on start).
REQ-029 tiles_issued is 8 bits; it SHALL be compared for equality only and SHALL never wrap within a job.

Reset
REQ-030 While rst=1, state SHALL be IDLE and the window, counters, valid pipe and FIFO SHALL be cleared.
REQ-031 Output reset values: s_ready=0, wc_D=0, m_valid=0, m_data=0, busy=0, done=0.
REQ-032 Reset mid-job SHALL discard in-flight and buffered tiles; no m_valid or done pulse SHALL follow.

Verification
REQ-033 Start with num_tiles=2 and stream 1..8, m_ready=1 -> tile1 issue window {5,4,3,2,1}; tile2 window {8,7,6,5,4}; two m_valid beats; done one cycle after the last pop.
REQ-034 Issue with m_ready=1 -> m_valid first high at issue+LAT+1 (cycle +3 at LAT=2); m_data equals the wc_Z of cycle issue+2.
REQ-035 num_tiles=8, m_ready=0 -> exactly 4 issues occur then s_ready stays 0; raising m_ready resumes issues; 8 tiles are delivered in order.
REQ-036 num_tiles=0 -> busy high for the DRAIN cycle; done pulses; s_ready never rises.
REQ-037 Assert rst with 2 tiles in flight -> all outputs 0 next cycle; a subsequent start with num_tiles=1 and samples 9..13 -> single tile from window {13,12,11,10,9}.
REQ-038 Pulse start while in RUN -> ignored; num_tiles latched value and tile count unchanged.
